// File: rtl/shift_issue_stage_pkg.sv
// shift_issue_stage_pkg: shared encodings and field positions for the shift issue stage
package shift_issue_stage_pkg;
  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;
  localparam logic [1:0] SHOP_SLL   = 2'b00;
  localparam logic [1:0] SHOP_SRL   = 2'b01;
  localparam logic [1:0] SHOP_SRA   = 2'b10;
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  // funct[1:0] picks the direction/kind; funct[2] only marks variable shifts
  function automatic logic [1:0] shop_of(input logic [5:0] funct);
    return funct[1] ? (funct[0] ? SHOP_SRA : SHOP_SRL) : SHOP_SLL;
  endfunction
endpackage

// File: rtl/shift_issue_stage_forward_mux.sv
// forward_mux: picks EX, then MEM, then register-file data for one source register
module forward_mux
  import shift_issue_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [4:0]   src,
  input  logic [W-1:0] rf_data,
  input  logic         ex_wr_en,
  input  logic [4:0]   ex_wr_reg,
  input  logic [W-1:0] ex_wr_data,
  input  logic         mem_wr_en,
  input  logic [4:0]   mem_wr_reg,
  input  logic [W-1:0] mem_wr_data,
  output logic [W-1:0] data
);
  // register 0 is hardwired to zero, so no forward source may override it
  always_comb
    data = (src == 5'd0) ? '0 :
           (ex_wr_en && ex_wr_reg == src) ? ex_wr_data :
           (mem_wr_en && mem_wr_reg == src) ? mem_wr_data : rf_data;
endmodule

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes shifts, forwards operands, detects load-use, registers shifter inputs
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [31:0]        in_instr,
  input  logic [DATA_W-1:0]  in_rs_data,
  input  logic [DATA_W-1:0]  in_rt_data,
  input  logic               stall_in,
  input  logic               flush,
  input  logic               ex_wr_en,
  input  logic [4:0]         ex_wr_reg,
  input  logic [DATA_W-1:0]  ex_wr_data,
  input  logic               ex_is_load,
  input  logic               mem_wr_en,
  input  logic [4:0]         mem_wr_reg,
  input  logic [DATA_W-1:0]  mem_wr_data,
  output logic               stall_req,
  output logic               out_valid,
  output logic [DATA_W-1:0]  ShiftOperand,
  output logic [SHAMT_W-1:0] ShiftAmount,
  output logic [1:0]         shift_op,
  output logic [4:0]         out_dest,
  output logic               out_wr_en
);
  logic [5:0]         opcode, funct;
  logic [4:0]         rs, rt, rd, shamt;
  logic               is_shift, variable, capture;
  logic [DATA_W-1:0]  rs_fwd, rt_fwd;
  logic               unused_rs_hi;
  assign opcode   = in_instr[OPC_LSB +: 6];
  assign rs       = in_instr[RS_LSB +: 5];
  assign rt       = in_instr[RT_LSB +: 5];
  assign rd       = in_instr[RD_LSB +: 5];
  assign shamt    = in_instr[SHAMT_LSB +: 5];
  assign funct    = in_instr[FUNCT_LSB +: 6];
  assign variable = funct[2];
  // only the low bits of rs feed the shifter, so a shift of 33 acts as 1
  assign unused_rs_hi = ^rs_fwd[DATA_W-1:SHAMT_W];
  // recognise the six R-type shift functs
  always_comb
    is_shift = in_valid && opcode == OPC_RTYPE &&
               (funct == FUNCT_SLL  || funct == FUNCT_SRL  || funct == FUNCT_SRA ||
                funct == FUNCT_SLLV || funct == FUNCT_SRLV || funct == FUNCT_SRAV);
  // a pending EX load feeding rt (or rs on a variable shift) cannot be forwarded yet
  always_comb
    stall_req = is_shift && ex_wr_en && ex_is_load && ex_wr_reg != 5'd0 &&
                (ex_wr_reg == rt || (variable && ex_wr_reg == rs));
  assign capture = is_shift && !stall_req;
  forward_mux #(.W(DATA_W)) u_fwd_rs (
    .src(rs), .rf_data(in_rs_data),
    .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_wr_data(mem_wr_data),
    .data(rs_fwd)
  );
  forward_mux #(.W(DATA_W)) u_fwd_rt (
    .src(rt), .rf_data(in_rt_data),
    .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_wr_data(mem_wr_data),
    .data(rt_fwd)
  );
  // stage register: reset > flush > stall_in > hazard bubble > capture
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_wr_en    <= 1'b0;
      ShiftOperand <= '0;
      ShiftAmount  <= '0;
      shift_op     <= SHOP_SLL;
      out_dest     <= 5'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_wr_en <= 1'b0;
    end else if (!stall_in) begin
      out_valid    <= capture;
      out_wr_en    <= capture && rd != 5'd0;
      ShiftOperand <= rt_fwd;
      ShiftAmount  <= variable ? rs_fwd[SHAMT_W-1:0] : shamt;
      shift_op     <= shop_of(funct);
      out_dest     <= rd;
    end
  end
endmodule
